// File: rtl/proc_run_ctrl_if.sv
// rtl/proc_run_ctrl_if.sv - data-memory store bus (and optional store-log stream) between core side and run controller
//
// Purpose: groups the core's data-memory store strobe/address/data and, when
//          STORE_LOG_EN is defined, the store-log pop stream.
// Signals:
//   DM_writeEnable  core store strobe
//   DM_addr         core store address (N bits)
//   DM_writeData    core store data (N bits)
//   log_valid/log_ready/log_addr/log_data/log_overflow  (STORE_LOG_EN only)
// Modports:
//   master  core/consumer side: drives the store bus and log_ready
//   slave   run controller: receives the store bus, drives the log stream
// Macro: STORE_LOG_EN

interface proc_run_ctrl_if #(
  parameter int N = 64
);
  logic         DM_writeEnable;
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
`ifdef STORE_LOG_EN
  logic         log_valid;
  logic         log_ready;
  logic [N-1:0] log_addr;
  logic [N-1:0] log_data;
  logic         log_overflow;

  modport master (
    output DM_writeEnable, DM_addr, DM_writeData, log_ready,
    input  log_valid, log_addr, log_data, log_overflow
  );
  modport slave (
    input  DM_writeEnable, DM_addr, DM_writeData, log_ready,
    output log_valid, log_addr, log_data, log_overflow
  );
`else
  modport master (
    output DM_writeEnable, DM_addr, DM_writeData
  );
  modport slave (
    input  DM_writeEnable, DM_addr, DM_writeData
  );
`endif
endinterface

// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - run-control sequencer for the single-cycle ARM core
//
// Purpose: holds the core in reset, releases it for a bounded run, ends the run
//          on a cycle budget or a store to HALT_ADDR, then requests a dump for a
//          fixed window and parks in DONE until the next start.
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   asynchronous, active-low
//   start        in   1-cycle pulse, honoured in IDLE and DONE only
//   dm           slave modport of proc_run_ctrl_if (store bus, optional log stream)
//   cpu_reset    out  active-high reset to the core
//   dump         out  dump request to the core
//   done         out  high in DONE
//   halted       out  run ended by a HALT_ADDR store (sticky until next start)
//   cycle_count  out  cycles spent in RUN (saturating)
//   store_count  out  stores seen in RUN (saturating)
//   state        out  IDLE=0 RST=1 RUN=2 DUMP=3 DONE=4
// Macro: STORE_LOG_EN adds a LOG_DEPTH-entry store log FIFO (LOG_DEPTH power of 2, >= 2).

module proc_run_ctrl #(
  parameter int           N            = 64,
  parameter int           CNT_W        = 32,
  parameter int           RESET_CYCLES = 2,
  parameter int           RUN_CYCLES   = 400,
  parameter int           DUMP_CYCLES  = 2000,
  parameter logic [N-1:0] HALT_ADDR    = '1,
  parameter int           LOG_DEPTH    = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  proc_run_ctrl_if.slave    dm,
  output logic              cpu_reset,
  output logic              dump,
  output logic              done,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_RUN  = 3'd2,
    S_DUMP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Terminal values of the shared phase timer; a zero-length phase still lasts one cycle.
  localparam logic [31:0]      RST_LAST    = (RESET_CYCLES > 1) ? 32'(RESET_CYCLES - 1) : 32'd0;
  localparam logic [31:0]      DUMP_LAST   = (DUMP_CYCLES  > 1) ? 32'(DUMP_CYCLES  - 1) : 32'd0;
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
  localparam logic             RUN_LIMITED = (RUN_CYCLES != 0);

  state_t      st;
  logic [31:0] timer;
  logic        go;
  logic        halt_hit;
  logic        budget_hit;

  assign go         = start && (st == S_IDLE || st == S_DONE);
  assign halt_hit   = (st == S_RUN) && dm.DM_writeEnable && (dm.DM_addr == HALT_ADDR);
  assign budget_hit = (st == S_RUN) && RUN_LIMITED && (cycle_count == RUN_LAST);
  assign state      = st;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      st          <= S_IDLE;
      timer       <= 32'd0;
      cpu_reset   <= 1'b1;
      dump        <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
      store_count <= '0;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            st          <= S_RST;
            timer       <= 32'd0;
            cpu_reset   <= 1'b1;
            dump        <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
            store_count <= '0;
          end
        end
        S_RST: begin
          if (timer == RST_LAST) begin
            st        <= S_RUN;
            cpu_reset <= 1'b0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          // The halting store is itself counted.
          if (dm.DM_writeEnable && store_count != '1) store_count <= store_count + 1'b1;
          if (halt_hit || budget_hit) begin
            st    <= S_DUMP;
            dump  <= 1'b1;
            timer <= 32'd0;
            if (halt_hit) halted <= 1'b1;
          end
        end
        S_DUMP: begin
          // Core stays out of reset so it keeps running its dump logic.
          if (timer == DUMP_LAST) begin
            st        <= S_DONE;
            dump      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: begin
          st        <= S_IDLE;
          cpu_reset <= 1'b1;
          dump      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef STORE_LOG_EN
  localparam int AW = $clog2(LOG_DEPTH);

  logic [N-1:0] mem_addr [LOG_DEPTH];
  logic [N-1:0] mem_data [LOG_DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         overflow;
  logic         full;
  logic         push;
  logic         pop;
  logic         push_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = (st == S_RUN) && dm.DM_writeEnable;
  assign pop     = dm.log_valid && dm.log_ready;
  // On full, a same-cycle pop frees the slot the push lands in.
  assign push_ok = push && (!full || pop);

  assign dm.log_valid    = (wr_ptr != rd_ptr);
  assign dm.log_addr     = mem_addr[rd_ptr[AW-1:0]];
  assign dm.log_data     = mem_data[rd_ptr[AW-1:0]];
  assign dm.log_overflow = overflow;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (go) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem_addr[wr_ptr[AW-1:0]] <= dm.DM_addr;
      mem_data[wr_ptr[AW-1:0]] <= dm.DM_writeData;
    end
  end
`else
  logic unused_nolog;
  assign unused_nolog = ^{dm.DM_writeData, LOG_DEPTH[0]};
`endif

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb/tb_proc_run_ctrl.sv - self-checking bench for proc_run_ctrl against a phase/countdown reference model

module tb_proc_run_ctrl;

  localparam int           N            = 16;
  localparam int           CNT_W        = 32;
  localparam int           RESET_CYCLES = 2;
  localparam int           RUN_CYCLES   = 10;
  localparam int           DUMP_CYCLES  = 4;
  localparam logic [N-1:0] HALT_ADDR    = 16'hFFFF;
  localparam int           LOG_DEPTH    = 4;
  localparam longint       CMAX         = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             cpu_reset, dump, done, halted;
  logic [CNT_W-1:0] cycle_count, store_count;
  logic [2:0]       state;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  proc_run_ctrl_if #(.N(N)) dm_if ();

  proc_run_ctrl #(
    .N(N), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES), .RUN_CYCLES(RUN_CYCLES),
    .DUMP_CYCLES(DUMP_CYCLES), .HALT_ADDR(HALT_ADDR), .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .CLOCK_50(clk), .reset(rst_n), .start(start), .dm(dm_if),
    .cpu_reset(cpu_reset), .dump(dump), .done(done), .halted(halted),
    .cycle_count(cycle_count), .store_count(store_count), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: spec state number plus cycles left in the timed phases.
  typedef struct { logic [N-1:0] a; logic [N-1:0] d; } log_t;
  int     m_state = 0;
  int     m_left  = 0;
  longint m_cyc   = 0;
  longint m_st    = 0;
  bit     m_halt  = 0;
  log_t   m_log[$];
  bit     m_ovf   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_cyc = 0; m_st = 0; m_halt = 0; m_ovf = 0;
    m_log.delete();
  endtask

  task automatic model_step();
    bit   h, b;
    log_t e;
`ifdef STORE_LOG_EN
    if (m_log.size() > 0 && dm_if.log_ready) void'(m_log.pop_front());
`endif
    case (m_state)
      0, 4: if (start) begin
        m_state = 1; m_left = RESET_CYCLES; m_cyc = 0; m_st = 0; m_halt = 0;
        m_log.delete(); m_ovf = 0;
      end
      1: begin m_left--; if (m_left <= 0) m_state = 2; end
      2: begin
        h = dm_if.DM_writeEnable && (dm_if.DM_addr == HALT_ADDR);
        b = (RUN_CYCLES != 0) && (m_cyc == RUN_CYCLES - 1);
        if (dm_if.DM_writeEnable) begin
          if (m_st < CMAX) m_st++;
          e.a = dm_if.DM_addr; e.d = dm_if.DM_writeData;
          if (m_log.size() < LOG_DEPTH) m_log.push_back(e); else m_ovf = 1;
        end
        if (m_cyc < CMAX) m_cyc++;
        if (h || b) begin m_state = 3; m_left = DUMP_CYCLES; if (h) m_halt = 1; end
      end
      3: begin m_left--; if (m_left <= 0) m_state = 4; end
      default: m_state = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("state", 64'(state), 64'(m_state));
      chk("cpu_reset", 64'(cpu_reset), 64'(m_state == 0 || m_state == 1 || m_state == 4));
      chk("dump", 64'(dump), 64'(m_state == 3));
      chk("done", 64'(done), 64'(m_state == 4));
      chk("halted", 64'(halted), 64'(m_halt));
      chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
      chk("store_count", 64'(store_count), 64'(m_st));
`ifdef STORE_LOG_EN
      chk("log_valid", 64'(dm_if.log_valid), 64'(m_log.size() > 0));
      chk("log_overflow", 64'(dm_if.log_overflow), 64'(m_ovf));
      if (m_log.size() > 0) begin
        chk("log_addr", 64'(dm_if.log_addr), 64'(m_log[0].a));
        chk("log_data", 64'(dm_if.log_data), 64'(m_log[0].d));
      end
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic set_store(input bit we, input bit is_halt);
    dm_if.DM_writeEnable = we;
    dm_if.DM_addr        = is_halt ? HALT_ADDR : N'($urandom_range(0, 16'hFFFE));
    dm_if.DM_writeData   = N'($urandom);
  endtask

`ifdef STORE_LOG_EN
  logic [N-1:0] exp_a [6];
  logic [N-1:0] exp_d [6];
`endif

  initial begin
    dm_if.DM_writeEnable = 1'b0;
    dm_if.DM_addr        = '0;
    dm_if.DM_writeData   = '0;
`ifdef STORE_LOG_EN
    dm_if.log_ready = 1'b1;
`endif
    #2 rst_n = 1'b0;
    checking = 1'b1;
    tick(3);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("reset_counts", 64'({cycle_count, store_count}), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // 1: start -> cpu_reset low exactly RESET_CYCLES later
    pulse_start();
    chk("t1_rst", 64'(state), 64'd1);
    tick(1);
    chk("t1_rst_hold", 64'(cpu_reset), 64'd1);
    tick(1);
    chk("t1_run", 64'(state), 64'd2);
    chk("t1_cpu_reset_low", 64'(cpu_reset), 64'd0);

    // 2: budget ends the run
    tick(RUN_CYCLES - 1);
    chk("t2_still_run", 64'(state), 64'd2);
    tick(1);
    chk("t2_dump", 64'(dump), 64'd1);
    chk("t2_cycles", 64'(cycle_count), 64'd10);
    chk("t2_halted", 64'(halted), 64'd0);
    tick(DUMP_CYCLES - 1);
    chk("t2_dump_last", 64'(dump), 64'd1);
    tick(1);
    chk("t2_done", 64'({done, dump, cpu_reset}), 64'b101);
    chk("t2_cycles_hold", 64'(cycle_count), 64'd10);

    // 3: stores at RUN cycles 2,3,5, halt store at 6
    pulse_start();
    tick(RESET_CYCLES);
    for (int k = 0; k <= 6; k++) begin
      set_store(k == 2 || k == 3 || k == 5 || k == 6, k == 6);
      tick(1);
    end
    set_store(1'b0, 1'b0);
    chk("t3_state", 64'(state), 64'd3);
    chk("t3_halted", 64'(halted), 64'd1);
    chk("t3_stores", 64'(store_count), 64'd4);
    chk("t3_cycles", 64'(cycle_count), 64'd7);
    tick(DUMP_CYCLES);

    // 4: halt on the last budget cycle, start pulses in RUN/DUMP ignored
    pulse_start();
    tick(RESET_CYCLES);
    for (int k = 0; k < RUN_CYCLES; k++) begin
      set_store(k == RUN_CYCLES - 1 || $urandom_range(0, 2) == 0, k == RUN_CYCLES - 1);
      start = (k == 4);
      tick(1);
    end
    start = 1'b0;
    set_store(1'b0, 1'b0);
    chk("t4_state", 64'(state), 64'd3);
    chk("t4_halted", 64'(halted), 64'd1);
    chk("t4_cycles", 64'(cycle_count), 64'd10);
    pulse_start();
    chk("t4_start_in_dump", 64'(state), 64'd3);
    tick(DUMP_CYCLES);

    // 5: asynchronous reset during DUMP
    pulse_start();
    tick(RESET_CYCLES + RUN_CYCLES + 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("t5_async_dump", 64'(dump), 64'd0);
    chk("t5_async_state", 64'(state), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

`ifdef STORE_LOG_EN
    // 6: log fills, overflows, drains in order
    dm_if.log_ready = 1'b0;
    pulse_start();
    tick(RESET_CYCLES);
    for (int k = 0; k < 6; k++) begin
      set_store(1'b1, 1'b0);
      exp_a[k] = dm_if.DM_addr;
      exp_d[k] = dm_if.DM_writeData;
      tick(1);
    end
    set_store(1'b0, 1'b0);
    chk("t6_overflow", 64'(dm_if.log_overflow), 64'd1);
    dm_if.log_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t6_valid", 64'(dm_if.log_valid), 64'd1);
      chk("t6_addr", 64'(dm_if.log_addr), 64'(exp_a[k]));
      chk("t6_data", 64'(dm_if.log_data), 64'(exp_d[k]));
      tick(1);
    end
    chk("t6_empty", 64'(dm_if.log_valid), 64'd0);
    tick(RUN_CYCLES + DUMP_CYCLES);
`endif

    // Randomized traffic checked cycle by cycle against the model
    pulse_start();
    for (int c = 0; c < 1500; c++) begin
      set_store($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
      start = ($urandom_range(0, 11) == 0);
`ifdef STORE_LOG_EN
      dm_if.log_ready = ($urandom_range(0, 3) != 0);
`endif
      rst_n = ($urandom_range(0, 249) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    start = 1'b0;
    set_store(1'b0, 1'b0);
    tick(2);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
